// File: rtl/stim_sweep_driver_pkg.sv
// stim_sweep_driver_pkg: shared state encoding and default sizing for board stimulus drivers
package stim_sweep_driver_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    localparam int ARG_MAX_DEF = 24;
    localparam int DIV_BITS_DEF = 27;
endpackage

// File: rtl/stim_sweep_driver_if.sv
// stim_sweep_driver_if: valid/ready argument and result channels between driver and compute DUT
interface stim_sweep_driver_if #(parameter int W = 16);
    logic in_valid;
    logic in_ready;
    logic [W-1:0] arg;
    logic out_valid;
    logic out_ready;
    logic [W-1:0] result;
    modport master (output in_valid, arg, out_ready, input in_ready, out_valid, result);
    modport slave (input in_valid, arg, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/stim_sweep_driver_tick_div.sv
// stim_tick_div: free-running divider held at zero by clr; ticks whenever it sits at zero while enabled
module stim_tick_div #(
    parameter int BITS = 27
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    output logic tick
);
    logic [BITS-1:0] cnt;

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) cnt <= '0;
        else cnt <= clr ? '0 : cnt + 1'b1;

    assign tick = !clr && cnt == '0;
endmodule

// File: rtl/stim_sweep_driver.sv
// stim_sweep_driver: turns switches or an auto sweep into DUT requests and latches results for the LEDs
module stim_sweep_driver
    import stim_sweep_driver_pkg::*;
#(
    parameter int W        = 16,
    parameter int ARG_BITS = 5,
    parameter int ARG_MAX  = ARG_MAX_DEF,
    parameter int DIV_BITS = DIV_BITS_DEF,
    parameter int TO_BITS  = 20
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [15:0]          sw,
    stim_sweep_driver_if.master  dut,
    output logic [W-1:0]         led_out,
    output logic                 busy,
    output logic                 timeout
);
    localparam logic [ARG_BITS:0] MAX_X = (ARG_BITS + 1)'(ARG_MAX);

    if (ARG_MAX >= 2 ** ARG_BITS) begin : g_arg_max_check
        $error("ARG_MAX must be below 2**ARG_BITS");
    end

    state_t state, nxt;
    logic [ARG_BITS-1:0] arg, sw_arg, arg_next;
    logic [ARG_BITS:0] arg_inc;
    logic [TO_BITS-1:0] tocnt;
    logic auto_mode, tick, manual_req, unused_sw;

    assign auto_mode  = sw[15];
    assign sw_arg     = sw[ARG_BITS-1:0];
    assign unused_sw  = ^sw[14:ARG_BITS];
    assign arg_inc    = {1'b0, arg} + (ARG_BITS + 1)'(1);
    assign arg_next   = (arg_inc > MAX_X) ? '0 : arg_inc[ARG_BITS-1:0];
    assign manual_req = sw_arg != arg && {1'b0, sw_arg} <= MAX_X;

    stim_tick_div #(.BITS(DIV_BITS)) u_div (
        .clk  (clk),
        .nrst (nrst),
        .clr  (!auto_mode),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (auto_mode ? tick : manual_req) ? ISSUE : IDLE;
            ISSUE:   nxt = dut.in_ready ? WAIT : ISSUE;
            WAIT:    nxt = (dut.out_valid || &tocnt) ? IDLE : WAIT;
            default: nxt = IDLE;
        endcase
    end

    // arg only moves on IDLE->ISSUE, so it stays stable across ISSUE and WAIT
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            arg     <= '0;
            tocnt   <= '0;
            led_out <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && nxt == ISSUE) arg <= auto_mode ? arg_next : sw_arg;
            tocnt <= (state == WAIT) ? tocnt + 1'b1 : '0;
            if (state == WAIT && dut.out_valid) begin
                led_out <= dut.result;
                timeout <= 1'b0;
            end else if (state == WAIT && &tocnt) timeout <= 1'b1;
        end

    always_comb begin
        dut.in_valid  = state == ISSUE;
        dut.out_ready = state == WAIT;
        dut.arg       = W'(arg);
        busy          = state != IDLE;
    end
endmodule
